// File: rtl/axi_dma_regs_pkg.sv
// AXI DMA S2MM register map, DMASR bit positions, AXI response codes and the
// kickoff FSM state type shared by the kickoff master and its write engine.
package axi_dma_regs_pkg;

    localparam logic [9:0] DMACR_OFF  = 10'h030;
    localparam logic [9:0] DMASR_OFF  = 10'h034;
    localparam logic [9:0] DA_OFF     = 10'h048;
    localparam logic [9:0] LENGTH_OFF = 10'h058;

    localparam int DMASR_IDLE_BIT    = 1;
    localparam int DMASR_INT_ERR_BIT = 4;
    localparam int DMASR_SLV_ERR_BIT = 5;
    localparam int DMASR_DEC_ERR_BIT = 6;
    localparam int DMASR_IOC_BIT     = 12;

    localparam logic [1:0]  RESP_OKAY = 2'b00;
    localparam logic [31:0] DMACR_RS  = 32'h0000_0001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WB,
        ST_POLL_AR,
        ST_POLL_R
    } kick_state_t;

    // Register written at each step of the kickoff sequence.
    function automatic logic [9:0] reg_offset(input logic [1:0] idx);
        case (idx)
            2'd0:    return DMACR_OFF;
            2'd1:    return DA_OFF;
            default: return LENGTH_OFF;
        endcase
    endfunction

endpackage

// File: rtl/axil_single_write.sv
// One AXI-Lite AW+W+B write. AW and W are raised together on i_go and each
// drops on its own handshake; bready rises once both have been accepted.
module axil_single_write
    import axi_dma_regs_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_go,
    input  logic [9:0]  i_addr,
    input  logic [31:0] i_data,
    output logic [9:0]  o_awaddr,
    output logic        o_awvalid,
    input  logic        i_awready,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_wstrb,
    output logic        o_wvalid,
    input  logic        i_wready,
    input  logic [1:0]  i_bresp,
    input  logic        i_bvalid,
    output logic        o_bready,
    output logic        o_req_done,
    output logic        o_b_done,
    output logic        o_b_ok
);

    logic        r_awvalid;
    logic        r_wvalid;
    logic        r_bready;
    logic [9:0]  r_addr;
    logic [31:0] r_data;
    logic        w_aw_left;
    logic        w_w_left;

    assign w_aw_left  = r_awvalid & ~i_awready;
    assign w_w_left   = r_wvalid & ~i_wready;
    assign o_req_done = (r_awvalid | r_wvalid) & ~w_aw_left & ~w_w_left;
    assign o_b_done   = r_bready & i_bvalid;
    assign o_b_ok     = (i_bresp == RESP_OKAY);

    assign o_awaddr  = r_addr;
    assign o_awvalid = r_awvalid;
    assign o_wdata   = r_data;
    assign o_wstrb   = 4'hF;
    assign o_wvalid  = r_wvalid;
    assign o_bready  = r_bready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
        end else if (i_go) begin
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_bready  <= 1'b0;
            r_addr    <= i_addr;
            r_data    <= i_data;
        end else begin
            r_awvalid <= w_aw_left;
            r_wvalid  <= w_w_left;
            if (o_req_done) begin
                r_bready <= 1'b1;
            end else if (o_b_done) begin
                r_bready <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/axi_dma_s2mm_kickoff.sv
// AXI-Lite master that starts an AXI DMA S2MM receive: DMACR.RS, DA, LENGTH.
// Define AXI_DMA_KICKOFF_POLL_EN to poll DMASR for completion after LENGTH.
module axi_dma_s2mm_kickoff
    import axi_dma_regs_pkg::*;
#(
    parameter int LEN_W    = 26,
    parameter int POLL_MAX = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] length,
    output logic             busy,
    output logic             done,
    output logic             error,
    output kick_state_t      dbg_state,
    output logic [9:0]       m_axil_awaddr,
    output logic             m_axil_awvalid,
    input  logic             m_axil_awready,
    output logic [31:0]      m_axil_wdata,
    output logic [3:0]       m_axil_wstrb,
    output logic             m_axil_wvalid,
    input  logic             m_axil_wready,
    input  logic [1:0]       m_axil_bresp,
    input  logic             m_axil_bvalid,
    output logic             m_axil_bready,
    output logic [9:0]       m_axil_araddr,
    output logic             m_axil_arvalid,
    input  logic             m_axil_arready,
    input  logic [31:0]      m_axil_rdata,
    input  logic [1:0]       m_axil_rresp,
    input  logic             m_axil_rvalid,
    output logic             m_axil_rready
);

    kick_state_t      r_state;
    logic [1:0]       r_idx;
    logic [31:0]      r_dst;
    logic [LEN_W-1:0] r_len;
    logic             r_busy;
    logic             r_done;
    logic             r_error;

    logic        w_start_ok;
    logic        w_more;
    logic        w_go;
    logic [1:0]  w_next_idx;
    logic [31:0] w_wr_data;
    logic        w_req_done;
    logic        w_b_done;
    logic        w_b_ok;

    assign w_start_ok = (r_state == ST_IDLE) & start & (length != '0);
    assign w_more     = (r_state == ST_WB) & w_b_done & w_b_ok & (r_idx != 2'd2);
    assign w_go       = w_start_ok | w_more;
    assign w_next_idx = (r_state == ST_IDLE) ? 2'd0 : r_idx + 2'd1;

    always_comb begin
        w_wr_data = DMACR_RS;
        case (w_next_idx)
            2'd0:    w_wr_data = DMACR_RS;
            2'd1:    w_wr_data = r_dst;
            default: w_wr_data = 32'(r_len);
        endcase
    end

    axil_single_write u_wr (
        .clk        (clk),
        .rst        (rst),
        .i_go       (w_go),
        .i_addr     (reg_offset(w_next_idx)),
        .i_data     (w_wr_data),
        .o_awaddr   (m_axil_awaddr),
        .o_awvalid  (m_axil_awvalid),
        .i_awready  (m_axil_awready),
        .o_wdata    (m_axil_wdata),
        .o_wstrb    (m_axil_wstrb),
        .o_wvalid   (m_axil_wvalid),
        .i_wready   (m_axil_wready),
        .i_bresp    (m_axil_bresp),
        .i_bvalid   (m_axil_bvalid),
        .o_bready   (m_axil_bready),
        .o_req_done (w_req_done),
        .o_b_done   (w_b_done),
        .o_b_ok     (w_b_ok)
    );

`ifdef AXI_DMA_KICKOFF_POLL_EN
    localparam int POLL_CW = $clog2(POLL_MAX + 1);

    logic               r_arvalid;
    logic               r_rready;
    logic [POLL_CW-1:0] r_poll_cnt;
    logic               w_st_err;
    logic               w_st_done;

    assign w_st_err  = (m_axil_rresp != RESP_OKAY) | m_axil_rdata[DMASR_INT_ERR_BIT]
                     | m_axil_rdata[DMASR_SLV_ERR_BIT] | m_axil_rdata[DMASR_DEC_ERR_BIT];
    assign w_st_done = m_axil_rdata[DMASR_IOC_BIT] | m_axil_rdata[DMASR_IDLE_BIT];

    assign m_axil_araddr  = DMASR_OFF;
    assign m_axil_arvalid = r_arvalid;
    assign m_axil_rready  = r_rready;
`else
    localparam int unused_poll_max = POLL_MAX;
    logic w_unused_rd;

    assign w_unused_rd    = ^{m_axil_arready, m_axil_rdata, m_axil_rresp, m_axil_rvalid};
    assign m_axil_araddr  = '0;
    assign m_axil_arvalid = 1'b0;
    assign m_axil_rready  = 1'b0;
`endif

    assign busy      = r_busy;
    assign done      = r_done;
    assign error     = r_error;
    assign dbg_state = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_dst   <= '0;
            r_len   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
`ifdef AXI_DMA_KICKOFF_POLL_EN
            r_arvalid  <= 1'b0;
            r_rready   <= 1'b0;
            r_poll_cnt <= '0;
`endif
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (length == '0) begin
                            r_error <= 1'b1;
                        end else begin
                            r_dst   <= dst_addr;
                            r_len   <= length;
                            r_idx   <= 2'd0;
                            r_busy  <= 1'b1;
                            r_state <= ST_WR;
                        end
                    end
                end
                ST_WR: begin
                    if (w_req_done) r_state <= ST_WB;
                end
                ST_WB: begin
                    if (w_b_done) begin
                        if (!w_b_ok) begin
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else if (r_idx != 2'd2) begin
                            r_idx   <= r_idx + 2'd1;
                            r_state <= ST_WR;
                        end else begin
`ifdef AXI_DMA_KICKOFF_POLL_EN
                            r_arvalid  <= 1'b1;
                            r_poll_cnt <= '0;
                            r_state    <= ST_POLL_AR;
`else
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
`endif
                        end
                    end
                end
`ifdef AXI_DMA_KICKOFF_POLL_EN
                ST_POLL_AR: begin
                    if (m_axil_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_POLL_R;
                    end
                end
                ST_POLL_R: begin
                    if (m_axil_rvalid) begin
                        r_rready   <= 1'b0;
                        r_poll_cnt <= r_poll_cnt + POLL_CW'(1);
                        // Error bits win over completion bits in the same status word.
                        if (w_st_err || (!w_st_done &&
                            (r_poll_cnt + POLL_CW'(1)) == POLL_CW'(POLL_MAX))) begin
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else if (w_st_done) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= ST_POLL_AR;
                        end
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
